mem_readback: RTL and testbench
===============================

# mem_readback

Sequential readback engine for the block-RAM `memory` read port. On a start command it sweeps a contiguous address range by driving `raddr`, absorbs the memory's 1-cycle registered read latency, and presents each word on a valid/ready stream with full backpressure. It also accumulates a checksum so the bench and on-chip checks can confirm RAM contents after bitstream reinitialization. It sits beside `memory` inside a `top`, owns `raddr`, and leaves `waddr`/`din` untouched.

## Interface
- `WID_MEM`, 2: word width; must match the attached memory.
- `DEPTH_MEM`, 32768: memory depth, a power of two; addresses wrap modulo this.
- `clk` in 1: single clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request a sweep; sampled only in IDLE.
- `start_addr` in 32: first address; only the low log2(DEPTH_MEM) bits are used.
- `len` in 32: number of words to read; 0 is legal.
- `abort` in 1: synchronous flush to IDLE, with no `done`.
- `raddr` out 32: address to memory; upper bits are always 0.
- `mem_dout` in WID_MEM: memory read data, valid the cycle after an issue.
- `out_valid` out 1, `out_ready` in 1: stream handshake.
- `out_data` out WID_MEM: word read from memory.
- `out_addr` out 32: address the word came from.
- `out_last` out 1: high on the final beat.
- `busy` out 1: high when state is not IDLE.
- `done` out 1: one-cycle pulse after the final beat transfers.
- `checksum` out 32: sum of zero-extended `out_data` over transferred beats, mod 2^32.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE → RUN:** when `start`=1 and `len`≠0. Latch `start_addr` (masked) into the address counter, load `len` into the issue counter and the beat counter, and clear `checksum`.
- **IDLE with `len`=0:** `start`=1 produces a `done` pulse on the next cycle, stays in IDLE, and issues no reads.
- **Ignored commands:** `start` is ignored outside IDLE.
- **Issue rule:** `occ` = buffered words + reads in flight, range 0..2. A read issues in a cycle when state is RUN, the issue counter is nonzero, and (occ − pop) < 2, where pop = `out_valid`&&`out_ready`.
- **On issue:** `raddr` holds the current address during the issue cycle. The counter then advances by 1, wrapping from DEPTH_MEM−1 to 0, and the issue counter decrements.
- **Raddr between issues:** `raddr` holds its last value. The memory reads unconditionally, so only issue-tagged data is captured.
- **Capture:** data returned in cycle C+1 on `mem_dout`, for an issue in cycle C, is written into a 2-entry FIFO with its address. The FIFO head drives `out_data`/`out_addr`.
- **RUN → DRAIN:** when the issue counter reaches 0.
- **DRAIN → IDLE:** when the beat counter reaches 0, that is, the last beat has transferred. `done` pulses in the first IDLE cycle.
- **`out_last`:** equals `out_valid` && beat counter == 1.
- **Beat transfer:** each transfer decrements the beat counter and adds the data to `checksum`. `checksum` holds its value after `done` until the next accepted `start`.
- **`abort`:** in any state, return to IDLE next cycle, empty the FIFO, discard in-flight data, and do not pulse `done`. `checksum` keeps its partial value. If `abort` and `start` arrive in the same IDLE cycle, `abort` wins.
- **`len` > DEPTH_MEM:** legal; addresses wrap and repeat.

## Timing
- **Reset values:** `raddr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `done`=0, `checksum`=0; state IDLE; FIFO empty.
- **Reset mid-sweep:** takes effect immediately (asynchronous); no `done`.
- **Startup latency:** `start` is sampled at edge E0; first issue in cycle E0+1; first `out_valid` in cycle E0+3.
- **Throughput:** with `out_ready` held at 1, one beat per cycle. The last beat is in cycle E0+2+`len`, and `done` in cycle E0+3+`len`.
- **Backpressure:** while `out_ready`=0, at most 2 words are held or in flight. `out_data`/`out_addr`/`out_last` stay stable while `out_valid`=1 and the beat is not taken.
- **Data ordering:** `out_valid` never depends combinationally on `out_ready`. Beats emerge in address order with no loss or duplication.

## Test plan
- **Continuous sweep:** memory init ram[i]=i mod 4, `start_addr`=0, `len`=8, `out_ready`=1 → data 0,1,2,3,0,1,2,3 with `out_addr` 0..7 on consecutive cycles from E0+3, `out_last` on addr 7, `done` at E0+11, `checksum`=12.
- **Wrap:** `start_addr`=32766, `len`=4 → `out_addr` 32766, 32767, 0, 1; `raddr` upper 17 bits are 0 throughout.
- **Backpressure:** `len`=6 with `out_ready` toggling 1,0,0,1,0,… → all 6 beats in order, outputs stable while stalled, `occ` never exceeds 2.
- **Zero length and ignored start:** `len`=0 → `done` pulse next cycle, no `out_valid`. Then `start` while `busy`=1 is ignored and the first sweep completes unchanged.
- **Abort:** `abort` two beats into `len`=100 → next cycle `busy`=0, `out_valid`=0, no `done`. An immediate new `start` with `len`=1 returns the correct single word.
- **Reset mid-sweep:** assert `reset` between edges mid-sweep → all outputs reach their reset values at once, with no edge needed; the next sweep after release behaves like a fresh one.

Source files
------------

// File: rtl/mem_readback.sv
// Sequential readback engine for a block-RAM read port: sweeps an address range,
// absorbs the 1-cycle read latency and streams words out with valid/ready and a checksum.
module mem_readback #(
  parameter int unsigned WID_MEM   = 2,
  parameter int unsigned DEPTH_MEM = 32768
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        start_addr,
  input  logic [31:0]        len,
  input  logic               abort,
  output logic [31:0]        raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WID_MEM-1:0] out_data,
  output logic [31:0]        out_addr,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic [31:0]        checksum
);

  localparam int unsigned AW = $clog2(DEPTH_MEM);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d, last_addr_q, inflight_addr_q;
  logic [31:0]       issue_cnt_q, issue_cnt_d, beat_cnt_q, beat_cnt_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              inflight_q, done_q, done_d;
  logic [WID_MEM-1:0] fifo_data_q [2];
  logic [AW-1:0]     fifo_addr_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        fifo_cnt_q, occ;
  logic              pop, issue;

  assign pop   = out_valid && out_ready;
  assign occ   = fifo_cnt_q + {1'b0, inflight_q};
  // A slot freed by this cycle's pop may be reused by this cycle's issue.
  assign issue = (state_q == StRun) && (issue_cnt_q != 32'd0) &&
                 ((occ - {1'b0, pop}) < 2'd2);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    checksum_d  = checksum_q;
    done_d      = 1'b0;
    if (pop) begin
      beat_cnt_d = beat_cnt_q - 32'd1;
      checksum_d = checksum_q + 32'(out_data);
    end
    if (issue) begin
      addr_d      = addr_q + AW'(1);
      issue_cnt_d = issue_cnt_q - 32'd1;
    end
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (len == 32'd0) begin
              done_d = 1'b1;
            end else begin
              state_d     = StRun;
              addr_d      = start_addr[AW-1:0];
              issue_cnt_d = len;
              beat_cnt_d  = len;
              checksum_d  = '0;
            end
          end
        end
        StRun: begin
          if (issue && (issue_cnt_q == 32'd1)) state_d = StDrain;
        end
        StDrain: begin
          if (pop && (beat_cnt_q == 32'd1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      last_addr_q     <= '0;
      inflight_addr_q <= '0;
      issue_cnt_q     <= '0;
      beat_cnt_q      <= '0;
      checksum_q      <= '0;
      inflight_q      <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      checksum_q  <= checksum_d;
      done_q      <= done_d;
      inflight_q  <= issue && !abort;
      if (issue) begin
        last_addr_q     <= addr_q;
        inflight_addr_q <= addr_q;
      end
    end
  end

  // Two-entry FIFO; the read issued last cycle lands here with its address tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_addr_q[0] <= '0;
      fifo_addr_q[1] <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= '0;
    end else if (abort) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= '0;
    end else begin
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= mem_dout;
        fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign raddr     = 32'(issue ? addr_q : last_addr_q);
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_addr  = 32'(fifo_addr_q[rd_ptr_q]);
  assign out_last  = out_valid && (beat_cnt_q == 32'd1);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_mem_readback.sv
// Scoreboard bench for mem_readback with a behavioural registered-read RAM (ram[i] = i mod 4).
module tb_mem_readback;

  localparam int unsigned Depth = 32768;

  typedef struct packed {
    logic [1:0]  data;
    logic [31:0] addr;
    logic        last;
  } exp_t;

  logic        clk, reset, start, abort, out_valid, out_ready, out_last, busy, done;
  logic [31:0] start_addr, len, raddr, out_addr, checksum;
  logic [1:0]  mem_dout, out_data;
  logic [1:0]  ram [Depth];

  exp_t sb[$];
  int   n_checks = 0, n_err = 0;
  int   cyc = 0, e0 = 0;
  int   done_cnt = 0, done_cyc = 0, beats = 0, rise_cyc = 0;
  logic [31:0] model_sum = 0;
  logic        stall_q = 0, prev_valid = 0, prev_last = 0;
  logic [1:0]  prev_data = 0;
  logic [31:0] prev_addr = 0;

  mem_readback #(.WID_MEM(2), .DEPTH_MEM(Depth)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .len(len),
    .abort(abort), .raddr(raddr), .mem_dout(mem_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_dout <= ram[raddr[14:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, predicts transfers at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (start && !busy && !abort && len != 0) model_sum = 0;
      if (busy) check("raddr_hi", 32'(raddr[31:15]), 32'd0);
      if (stall_q) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_addr", out_addr, prev_addr);
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("beat_data", 32'(out_data), 32'(e.data));
          check("beat_addr", out_addr, e.addr);
          check("beat_last", 32'(out_last), 32'(e.last));
          model_sum = model_sum + 32'(e.data);
          beats++;
        end
      end
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_q    = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_data  = out_data;
      prev_addr  = out_addr;
      prev_last  = out_last;
    end else begin
      stall_q    = 1'b0;
      prev_valid = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the edge that samples start.
  task automatic start_sweep(input int unsigned sa, input int unsigned l);
    exp_t e;
    int unsigned a;
    for (int unsigned k = 0; k < l; k++) begin
      a = (sa + k) % Depth;
      e.data = 2'(a % 4);
      e.addr = a;
      e.last = (k == l - 1);
      sb.push_back(e);
    end
    start = 1'b1;
    start_addr = sa;
    len = l;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != c0) break;
    end
    check(tag, 32'(done_cnt != c0), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_raddr"}, raddr, 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_addr"}, out_addr, 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_sum"}, checksum, 32'd0);
  endtask

  initial begin
    int c0, b0;
    for (int i = 0; i < Depth; i++) ram[i] = 2'(i % 4);
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start_addr = 0; len = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Continuous sweep
    start_sweep(0, 8);
    wait_done("sweep_done_timeout", 40);
    check("sweep_first_valid", 32'(rise_cyc - e0 + 1), 32'd3);
    check("sweep_done_cycle", 32'(done_cyc - e0 + 1), 32'd11);
    check("sweep_checksum", checksum, 32'd12);
    check("sweep_model_sum", checksum, model_sum);
    check("sweep_sb_empty", 32'(sb.size()), 32'd0);
    check("sweep_idle", 32'(busy), 32'd0);

    // Address wrap
    start_sweep(32766, 4);
    wait_done("wrap_done_timeout", 40);
    check("wrap_checksum", checksum, 32'd6);
    check("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure with ready pattern 1,0,0,1,0
    start_sweep(100, 6);
    c0 = done_cnt;
    for (int i = 0; i < 80; i++) begin
      out_ready = (i % 5 == 0) || (i % 5 == 3);
      @(posedge clk);
      #1;
      if (done_cnt != c0) break;
    end
    out_ready = 1'b1;
    check("bp_done", 32'(done_cnt - c0), 32'd1);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);
    check("bp_checksum", checksum, model_sum);

    // Zero length, then an ignored start while busy
    c0 = done_cnt;
    start_sweep(9, 0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("zero_done_pulse", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    start_sweep(200, 5);
    @(posedge clk);
    #1;
    start = 1'b1; start_addr = 5000; len = 3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign_done_timeout", 40);
    repeat (4) @(posedge clk);
    #1;
    check("ign_done_count", 32'(done_cnt - c0), 32'd2);
    check("ign_sb_empty", 32'(sb.size()), 32'd0);
    check("ign_idle", 32'(busy), 32'd0);
    check("ign_checksum", checksum, model_sum);

    // Abort two beats into a long sweep
    start_sweep(0, 100);
    b0 = beats;
    c0 = done_cnt;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (beats - b0 >= 2) break;
    end
    check("abort_two_beats", 32'(beats - b0 >= 2), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    start_sweep(37, 1);
    wait_done("abort_next_timeout", 20);
    check("abort_no_done", 32'(done_cnt - c0), 32'd1);
    check("abort_next_sum", checksum, 32'd1);
    check("abort_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-sweep
    start_sweep(0, 20);
    c0 = done_cnt;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_cnt - c0), 32'd0);
    start_sweep(10, 3);
    wait_done("midrst_done_timeout", 30);
    check("midrst_done_cycle", 32'(done_cyc - e0 + 1), 32'd6);
    check("midrst_checksum", checksum, 32'd5);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
